scan_clk_ctrl: RTL and testbench

SCAN_CLK_CTRL -- requirements
Module: scan_clk_ctrl

---
 rtl/scan_clk_ctrl_pkg.sv | 22 ++
 rtl/scan_clk_ctrl_div.sv | 34 +++
 rtl/scan_clk_ctrl.sv | 136 +++++++++++++
 tb/tb_scan_clk_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_clk_ctrl_pkg.sv
// rtl/scan_clk_ctrl_pkg.sv - shared encodings and defaults for the scan clock controller
package scan_clk_ctrl_pkg;

  localparam int DIV_W_DEF = 16;
  localparam int CH_W_DEF  = 4;
  localparam int RND_W     = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_HALF   = 2'd0,
    SEL_CHAN   = 2'd1,
    SEL_ROUNDS = 2'd2,
    SEL_NONE   = 2'd3
  } cfg_sel_t;

endpackage

// File: rtl/scan_clk_ctrl_div.sv
// rtl/scan_clk_ctrl_div.sv - half-period divider producing one tick per scan_clk toggle
module scan_clk_div
  import scan_clk_ctrl_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic [DIV_W-1:0] half_period,
  output logic             tick
);

  logic [DIV_W-1:0] count;

  // Count 0..half_period while enabled, so a tick arrives every half_period+1 cycles
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable) begin
      if (count == half_period) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  assign tick = enable && !load && (count == half_period);

endmodule

// File: rtl/scan_clk_ctrl.sv
// rtl/scan_clk_ctrl.sv - scan clock FSM, config registers and round/address tracking
module scan_clk_ctrl
  import scan_clk_ctrl_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int CH_W  = CH_W_DEF
) (
  input  logic            clk_sys,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_sel,
  input  logic [15:0]     cfg_data,
  input  logic            start,
  input  logic            stop,
  output logic            scan_clk,
  output logic            addr_rst_n,
  output logic [CH_W-1:0] chan_num,
  output logic            chan_load,
  output logic [CH_W-1:0] addr_mirror,
  output logic            busy,
  output logic            done
);

  state_t           state;
  logic [DIV_W-1:0] half_period;
  logic [CH_W-1:0]  chan_cnt;
  logic [RND_W-1:0] rounds;
  logic [RND_W-1:0] round_cnt;
  logic             tick;
  logic             div_load;
  logic             div_en;

  // The divider is held cleared through LOAD so RUN starts from a fresh count
  assign div_load = (state == S_LOAD);
  assign div_en   = (state == S_RUN);

  scan_clk_div #(
    .DIV_W(DIV_W)
  ) u_div (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .load       (div_load),
    .enable     (div_en),
    .half_period(half_period),
    .tick       (tick)
  );

  // Single FSM: config writes in IDLE, scan sequencing, and all registered outputs
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      half_period <= '0;
      chan_cnt    <= CH_W'(1);
      rounds      <= '0;
      round_cnt   <= '0;
      scan_clk    <= 1'b1;
      addr_rst_n  <= 1'b0;
      chan_load   <= 1'b0;
      chan_num    <= CH_W'(1);
      addr_mirror <= CH_W'(1);
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      chan_load  <= 1'b0;
      done       <= 1'b0;
      addr_rst_n <= 1'b1;
      case (state)
        S_IDLE: begin
          scan_clk <= 1'b1;
          if (cfg_we) begin
            case (cfg_sel_t'(cfg_sel))
              SEL_HALF:   half_period <= cfg_data[DIV_W-1:0];
              SEL_CHAN:   chan_cnt    <= (cfg_data[CH_W-1:0] == '0) ? CH_W'(1)
                                                                    : cfg_data[CH_W-1:0];
              SEL_ROUNDS: rounds      <= cfg_data;
              default:    ;
            endcase
          end
          if (start && !stop) begin
            state       <= S_LOAD;
            chan_load   <= 1'b1;
            chan_num    <= chan_cnt;
            addr_rst_n  <= 1'b0;
            addr_mirror <= CH_W'(1);
            round_cnt   <= '0;
            busy        <= 1'b1;
          end
        end
        S_LOAD: begin
          if (stop) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (rounds == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (stop) begin
            state    <= S_IDLE;
            scan_clk <= 1'b1;
            busy     <= 1'b0;
          end else if (tick) begin
            if (scan_clk) begin
              // Falling edge: downstream address stage advances, wrapping chan_cnt -> 1
              scan_clk <= 1'b0;
              if (addr_mirror == chan_cnt) begin
                addr_mirror <= CH_W'(1);
                round_cnt   <= round_cnt + 1'b1;
              end else begin
                addr_mirror <= addr_mirror + 1'b1;
              end
            end else begin
              scan_clk <= 1'b1;
              if (round_cnt == rounds) begin
                state <= S_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_clk_ctrl.sv
// tb/tb_scan_clk_ctrl.sv - self-checking bench for scan_clk_ctrl
module tb_scan_clk_ctrl;

  logic        clk_sys;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [15:0] cfg_data;
  logic        start;
  logic        stop;
  logic        scan_clk;
  logic        addr_rst_n;
  logic [3:0]  chan_num;
  logic        chan_load;
  logic [3:0]  addr_mirror;
  logic        busy;
  logic        done;

  int vectors = 0;
  int errors  = 0;

  scan_clk_ctrl dut (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_data   (cfg_data),
    .start      (start),
    .stop       (stop),
    .scan_clk   (scan_clk),
    .addr_rst_n (addr_rst_n),
    .chan_num   (chan_num),
    .chan_load  (chan_load),
    .addr_mirror(addr_mirror),
    .busy       (busy),
    .done       (done)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int hp;
    int ccw;
    int r;
    int exp_chan_num;
    int exp_falls;
  } vec_t;

  task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%0d required=%0d", tag, what, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic cfg_write(input int sel, input int data);
    cfg_we   = 1'b1;
    cfg_sel  = 2'(sel);
    cfg_data = 16'(data);
    step();
    cfg_we   = 1'b0;
  endtask

  task automatic cfg_all(input int hp, input int ccw, input int r);
    cfg_write(0, hp);
    cfg_write(1, ccw);
    cfg_write(2, r);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk(tag, "scan_clk", 32'(scan_clk), 1);
    chk(tag, "addr_rst_n", 32'(addr_rst_n), 0);
    chk(tag, "chan_load", 32'(chan_load), 0);
    chk(tag, "chan_num", 32'(chan_num), 1);
    chk(tag, "addr_mirror", 32'(addr_mirror), 1);
    chk(tag, "busy", 32'(busy), 0);
    chk(tag, "done", 32'(done), 0);
  endtask

  // Reference: scan_clk toggles at fixed multiples of half_period+1 after RUN entry,
  // falls number chan_cnt*rounds, the address after fall k is (k mod chan_cnt)+1.
  task automatic run_scan(input int hp, input int ccw, input int r, input bit junk, input string tag);
    int   cc, nf, t, m, falls, em, obs_falls;
    logic prev;
    cc = (ccw == 0) ? 1 : ccw;
    nf = cc * r;
    t  = 2 * nf * (hp + 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk(tag, "load_chan_load", 32'(chan_load), 1);
    chk(tag, "load_chan_num", 32'(chan_num), 32'(cc));
    chk(tag, "load_addr_rst_n", 32'(addr_rst_n), 0);
    chk(tag, "load_addr_mirror", 32'(addr_mirror), 1);
    chk(tag, "load_busy", 32'(busy), 1);
    chk(tag, "load_scan_clk", 32'(scan_clk), 1);
    prev = 1'b1;
    obs_falls = 0;
    for (int n = 1; n <= t + 2; n++) begin
      if (junk && n <= 3) begin
        cfg_we   = 1'b1;
        cfg_sel  = 2'(n - 1);
        cfg_data = 16'h0009;
      end
      step();
      cfg_we = 1'b0;
      m = (n - 1) / (hp + 1);
      if (m > 2 * nf) m = 2 * nf;
      falls = (m + 1) / 2;
      em = (falls == 0) ? 1 : (falls % cc) + 1;
      chk(tag, "scan_clk", 32'(scan_clk), 32'((m % 2) == 0));
      chk(tag, "addr_mirror", 32'(addr_mirror), 32'(em));
      chk(tag, "busy", 32'(busy), 32'(n <= t));
      chk(tag, "done", 32'(done), 32'(n == t + 1));
      chk(tag, "chan_load", 32'(chan_load), 0);
      chk(tag, "addr_rst_n", 32'(addr_rst_n), 1);
      if (prev && !scan_clk) obs_falls++;
      prev = scan_clk;
    end
    chk(tag, "fall_count", 32'(obs_falls), 32'(nf));
  endtask

  vec_t tbl [4];

  initial begin
    int k;
    int falls;
    int hp, ccw, r;
    logic prev;
    rst = 1'b1; cfg_we = 1'b0; cfg_sel = 2'd0; cfg_data = 16'd0; start = 1'b0; stop = 1'b0;

    tbl[0] = '{hp: 1, ccw: 3, r: 2, exp_chan_num: 3, exp_falls: 6};
    tbl[1] = '{hp: 0, ccw: 2, r: 0, exp_chan_num: 2, exp_falls: 0};
    tbl[2] = '{hp: 2, ccw: 0, r: 3, exp_chan_num: 1, exp_falls: 3};
    tbl[3] = '{hp: 0, ccw: 5, r: 1, exp_chan_num: 5, exp_falls: 5};

    // reset state and release
    repeat (2) @(posedge clk_sys);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
    step();
    chk("release", "addr_rst_n", 32'(addr_rst_n), 1);
    chk("release", "busy", 32'(busy), 0);

    // directed table
    for (int i = 0; i < 4; i++) begin
      cfg_all(tbl[i].hp, tbl[i].ccw, tbl[i].r);
      run_scan(tbl[i].hp, tbl[i].ccw, tbl[i].r, 1'b0, $sformatf("tbl%0d", i));
    end

    // stop after the second fall of a chan_cnt=4 run
    cfg_all(1, 4, 2);
    start = 1'b1;
    step();
    start = 1'b0;
    falls = 0;
    prev = 1'b1;
    k = 0;
    while (falls < 2 && k < 100) begin
      step();
      if (prev && !scan_clk) falls++;
      prev = scan_clk;
      k++;
    end
    chk("stop", "reached_2nd_fall", 32'(falls), 2);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop", "busy", 32'(busy), 0);
    chk("stop", "scan_clk", 32'(scan_clk), 1);
    chk("stop", "addr_mirror", 32'(addr_mirror), 3);
    chk("stop", "done", 32'(done), 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("stop_after", "done", 32'(done), 0);
      chk("stop_after", "scan_clk", 32'(scan_clk), 1);
      chk("stop_after", "addr_mirror", 32'(addr_mirror), 3);
    end

    // config writes during a scan are ignored
    cfg_all(0, 2, 1);
    run_scan(0, 2, 1, 1'b1, "junk_cfg");
    run_scan(0, 2, 1, 1'b0, "cfg_kept");

    // start and stop together in IDLE
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    chk("start_stop", "busy", 32'(busy), 0);
    chk("start_stop", "chan_load", 32'(chan_load), 0);
    step();
    chk("start_stop", "busy_later", 32'(busy), 0);
    chk("start_stop", "scan_clk", 32'(scan_clk), 1);

    // asynchronous reset in the middle of a scan
    cfg_all(1, 3, 2);
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (scan_clk !== 1'b0 && k < 50) begin
      step();
      k++;
    end
    chk("rst_mid", "reached_fall", 32'(scan_clk), 0);
    rst = 1'b1;
    #1;
    chk_reset_vals("rst_mid");
    #1;
    rst = 1'b0;
    step();
    chk("rst_mid_release", "addr_rst_n", 32'(addr_rst_n), 1);
    chk("rst_mid_release", "done", 32'(done), 0);
    chk("rst_mid_release", "busy", 32'(busy), 0);
    // defaults after reset: chan_cnt=1, rounds=0
    run_scan(0, 1, 0, 1'b0, "defaults");

    // randomized configurations
    for (int i = 0; i < 10; i++) begin
      hp  = int'($urandom_range(0, 3));
      ccw = int'($urandom_range(0, 6));
      r   = int'($urandom_range(0, 3));
      cfg_all(hp, ccw, r);
      cfg_write(3, int'($urandom_range(0, 65535)));
      run_scan(hp, ccw, r, 1'b0, $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
